// File: rtl/uart_pkg.sv
// UART definitions shared by the transmit and receive paths: default bit timing,
// FSM state encoding and frame constants.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 694;  // 80 MHz / 115200 baud
    localparam int unsigned DATA_BITS            = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata always shows the head entry.
// Full/empty come from the occupancy count, so pointers may wrap freely.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_BITS,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: host writes land in a FIFO that the serialiser
// drains back-to-back onto o_TX.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        i_Write,
    input  logic [7:0]                  i_Data,
    output logic                        o_Full,
    output logic [$clog2(FIFO_DEPTH):0] o_Count,
    output logic                        o_Overflow,
    output logic                        o_Busy,
    output logic                        o_TX
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    uart_state_e state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              overflow_q;

    logic                        push, pop, full, empty, bit_done;
    logic [7:0]                  head;
    logic [$clog2(FIFO_DEPTH):0] count;

    // Acceptance uses the registered full flag, so a same-cycle pop never rescues a write.
    assign push = i_Write && !full;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .wdata (i_Data),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bit_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            StData: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = StStop;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            StStop: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is decoded from the next state so o_TX changes on the same edge.
        tx_d = 1'b1;
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= i_Write && full;
        end
    end

    assign o_TX       = tx_q;
    assign o_Full     = full;
    assign o_Count    = count;
    assign o_Overflow = overflow_q;
    assign o_Busy     = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural RX decodes o_TX against a scoreboard of
// written bytes; a second small build checks exact frame timing and pointer wrap.
module tb_uart_tx_fifo;

    localparam int C  = 694;
    localparam int CS = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       wr = 1'b0, wr_s = 1'b0;
    logic [7:0] din = 8'h00, din_s = 8'h00;
    logic       full, ovf, busy, tx;
    logic [4:0] count;
    logic       full_s, ovf_s, busy_s, tx_s;
    logic [1:0] count_s;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_s[$];

    always #5 Clock = ~Clock;

    uart_tx_fifo #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (16)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .i_Write    (wr),
        .i_Data     (din),
        .o_Full     (full),
        .o_Count    (count),
        .o_Overflow (ovf),
        .o_Busy     (busy),
        .o_TX       (tx)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT (CS),
        .FIFO_DEPTH   (2)
    ) dut_s (
        .Clock      (Clock),
        .Reset      (Reset),
        .i_Write    (wr_s),
        .i_Data     (din_s),
        .o_Full     (full_s),
        .o_Count    (count_s),
        .o_Overflow (ovf_s),
        .o_Busy     (busy_s),
        .o_TX       (tx_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int limit, output int n);
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) chk({tag, "_timeout"}, busy, 0);
    endtask

    // Behavioural receiver: mid-bit sampling, abandons a frame if reset hits.
    initial begin : rx_monitor
        logic [9:0] bits;
        logic       ab;
        logic [7:0] e;
        bits = '0;
        forever begin
            @(posedge Clock);
            #2;
            if (tx === 1'b0 && Reset === 1'b0) begin
                ab = 1'b0;
                for (int k = 0; k < 10 && !ab; k++) begin
                    for (int j = 0; j < ((k == 0) ? C / 2 : C) && !ab; j++) begin
                        @(posedge Clock);
                        if (Reset) ab = 1'b1;
                    end
                    #2;
                    bits[k] = tx;
                end
                if (!ab) begin
                    chk("rx_start_bit", bits[0], 0);
                    chk("rx_stop_bit", bits[9], 1);
                    chk("rx_sb_avail", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("rx_byte", bits[8:1], e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1);
    end

    initial begin : stim
        int         n, t, ov_seen;
        logic [159:0] cap;
        logic [9:0]  fr;
        logic [39:0] ex;
        logic [7:0]  e;
        cap = '0;

        // Reset values
        tick();
        tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_tx_s", tx_s, 1);
        chk("rst_busy_s", busy_s, 0);
        Reset = 1'b0;
        tick();

        // Single byte 0x61 with first-edge latency and busy length
        wr = 1'b1; din = 8'h61; exp_q.push_back(8'h61);
        tick();
        wr = 1'b0;
        chk("a_tx_before_fall", tx, 1);
        tick();
        chk("a_tx_fall", tx, 0);
        wait_idle("a_idle", 8000, n);
        chk("a_busy_len", n, 10 * C);
        chk("a_sb_drained", exp_q.size(), 0);
        repeat (5) tick();

        // Three consecutive writes, back-to-back frames
        wr = 1'b1; din = 8'h61; exp_q.push_back(8'h61);
        tick();
        din = 8'h62; exp_q.push_back(8'h62);
        tick();
        chk("b_count_push_pop", count, 1);
        din = 8'h0A; exp_q.push_back(8'h0A);
        tick();
        wr = 1'b0;
        chk("b_count2", count, 2);
        wait_idle("b_idle", 22000, n);
        chk("b_busy_len", n + 1, 30 * C);
        chk("b_sb_drained", exp_q.size(), 0);
        repeat (5) tick();

        // Overflow: 17 writes after the first pop
        wr = 1'b1; din = 8'hAA; exp_q.push_back(8'hAA);
        tick();
        wr = 1'b0; t = 0;
        tick(); t++;
        ov_seen = 0;
        for (int i = 0; i <= 16; i++) begin
            wr = 1'b1; din = 8'(i);
            if (i < 16) exp_q.push_back(8'(i));
            tick(); t++;
            if (ovf === 1'b1) ov_seen++;
            if (i == 15) begin
                chk("c_full", full, 1);
                chk("c_count16", count, 16);
                chk("c_ovf_before", ovf, 0);
            end
            if (i == 16) begin
                chk("c_ovf_pulse", ovf, 1);
                chk("c_count_hold", count, 16);
            end
        end
        wr = 1'b0;
        repeat (4) begin
            tick(); t++;
            if (ovf === 1'b1) ov_seen++;
        end
        chk("c_ovf_pulses", ov_seen, 1);

        // Write on full in the same cycle as the end-of-stop pop
        while (t < 10 * C) begin
            tick(); t++;
        end
        chk("d_full_before", full, 1);
        wr = 1'b1; din = 8'h77;
        tick(); t++;
        wr = 1'b0;
        chk("d_ovf", ovf, 1);
        chk("d_count15", count, 15);
        chk("d_not_full", full, 0);
        chk("d_sb_head_done", exp_q.size(), 16);

        #2 Reset = 1'b1;
        exp_q.delete();
        repeat (3) tick();
        chk("d_rst_count", count, 0);
        Reset = 1'b0;
        tick();

        // Reset during data bit 3 of 0x55 with four bytes queued
        wr = 1'b1; din = 8'h55; exp_q.push_back(8'h55);
        tick(); t = 0;
        for (int i = 1; i <= 4; i++) begin
            din = 8'(8'h11 * i); exp_q.push_back(8'(8'h11 * i));
            tick(); t++;
        end
        wr = 1'b0;
        while (t < 1 + 4 * C + C / 2) begin
            tick(); t++;
        end
        chk("e_bit3_level", tx, 0);
        chk("e_queued", count, 4);
        #3 Reset = 1'b1;
        exp_q.delete();
        #1;
        chk("e_rst_tx", tx, 1);
        chk("e_rst_count", count, 0);
        chk("e_rst_busy", busy, 0);
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        wr = 1'b1; din = 8'hA5; exp_q.push_back(8'hA5);
        tick();
        wr = 1'b0;
        chk("e_a5_tx_hold", tx, 1);
        tick();
        chk("e_a5_tx_fall", tx, 0);
        wait_idle("e_idle", 8000, n);
        chk("e_a5_busy_len", n, 10 * C);
        chk("e_sb_drained", exp_q.size(), 0);

        // Small build: exact 40-clock frames and pointer wrap
        wr_s = 1'b1; din_s = 8'hFF; exp_s.push_back(8'hFF);
        tick();
        din_s = 8'h00; exp_s.push_back(8'h00);
        tick();
        wr_s = 1'b0;
        chk("f_tx_fall", tx_s, 0);
        cap[0] = tx_s;
        for (int i = 1; i < 160; i++) begin
            if (i == 50) begin
                wr_s = 1'b1; din_s = 8'h3C; exp_s.push_back(8'h3C);
            end
            if (i == 51) begin
                din_s = 8'hC3; exp_s.push_back(8'hC3);
            end
            if (i == 52) wr_s = 1'b0;
            tick();
            cap[i] = tx_s;
            if (i == 52) begin
                chk("f_full_s", full_s, 1);
                chk("f_count_s", count_s, 2);
            end
        end
        chk("f_busy_last", busy_s, 1);
        tick();
        chk("f_busy_fall", busy_s, 0);
        chk("f_tx_idle", tx_s, 1);
        for (int f = 0; f < 4; f++) begin
            e  = exp_s.pop_front();
            fr = {1'b1, e, 1'b0};
            for (int k = 0; k < 40; k++) ex[k] = fr[k / CS];
            chk("f_frame", cap[f * 40 +: 40], ex);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
